req_gnt_arbiter: RTL and testbench
==================================

Name: req_gnt_arbiter

Overview:
- Round-robin arbiter that shares one resource between N_REQ requesters using a req/gnt handshake.
- A grant becomes visible exactly GNT_DELAY clock edges after the winning request is sampled, so that "req ##GNT_DELAY gnt" holds for every grant.
- Sits in front of the shared datapath and drives its gnt/owner-select lines.
- Grant tenure is bounded by MAX_HOLD to guarantee fairness.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- GNT_DELAY, 2, edges from the request sample to gnt first sampled high (1..4).
- MAX_HOLD, 8, maximum consecutive cycles a grant may stay high (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- req  input  N_REQ  per-requester request, level-sensitive.
- gnt  output  N_REQ  registered, one-hot-or-zero grant.
- gnt_id  output  $clog2(N_REQ)  index of the current or pending owner; valid while busy=1.
- busy  output  1  high whenever state is not IDLE.
- expired  output  1  single-cycle pulse when a grant is revoked because MAX_HOLD was reached.

Behaviour:
- Reset (rst sampled high at an edge): state=IDLE, gnt=0, gnt_id=0, busy=0, expired=0, hold_cnt=0, dly_cnt=0, last=N_REQ-1 (requester 0 has first priority). Reset overrides all other events, including an active grant; gnt is 0 after that edge.
- State machine: IDLE, WAIT, GRANT.
- IDLE, on edge T with req!=0:
  - Winner = first set bit of req, searching circularly from (last+1) mod N_REQ.
  - gnt_id <= winner.
  - If GNT_DELAY==1: go to GRANT, and gnt[winner] is set at edge T.
  - Otherwise: go to WAIT with dly_cnt <= GNT_DELAY-2.
  - With req==0, stay in IDLE with all outputs 0.
- WAIT:
  - If req[gnt_id] is sampled low: abort to IDLE, issue no grant, leave last unchanged.
  - Else if dly_cnt==0: go to GRANT, set gnt[gnt_id], hold_cnt <= 1.
  - Else: dly_cnt decrements.
  - Net timing: request sampled at edge T, gnt first sampled high at edge T+GNT_DELAY.
- GRANT, each edge:
  - If req[gnt_id] is sampled low: clear gnt, last <= gnt_id, go to IDLE.
  - Else if hold_cnt==MAX_HOLD: clear gnt, pulse expired for one cycle, last <= gnt_id, go to IDLE.
  - Else: hold_cnt increments.
  - gnt is therefore sampled high on at most MAX_HOLD consecutive edges.
- After any release there is at least one IDLE cycle; a new arbitration occurs on the next edge. A requester that expired keeps requesting but has lowest priority in that arbitration.
- Requests from non-winners are ignored while busy; they are not queued, because req is a level signal.
- Simultaneous release and new request on the same edge: release is handled first; the new request is arbitrated on the following edge.
- Invariants:
  - popcount(gnt) <= 1.
  - gnt!=0 implies state==GRANT.
  - gnt[i] rises only if req[i] was high for the preceding GNT_DELAY sampled edges.
- Counters: hold_cnt is $clog2(MAX_HOLD+1) bits and dly_cnt is $clog2(GNT_DELAY) bits (minimum 1). Neither wraps.
- Embedded concurrent assertions are clocked on posedge clk and disabled iff rst:
  - one-hot-or-zero on gnt;
  - for each i, gnt[i] rising implies req[i] was high GNT_DELAY edges earlier;
  - gnt sampled high for no more than MAX_HOLD consecutive edges;
  - expired implies gnt==0 on the same cycle.

Test Plan:
- GNT_DELAY=2, single requester: req[1]=1 from edge 3 → gnt=4'b0010 sampled at edge 5, gnt_id=1, busy=1 from edge 3; req[1]=0 at edge 7 → gnt=0 after edge 7, busy=0.
- GNT_DELAY=1: req[0] sampled at edge 2 → gnt[0]=1 sampled at edge 3; the assertion req ##1 gnt passes.
- Round-robin: req=4'b1111 held continuously, MAX_HOLD=8 → grant order 0,1,2,3,0; each tenure is 8 gnt cycles; expired pulses after each tenure; one idle cycle between tenures.
- Abort: req[2] rises at edge 4 and drops at edge 5 (GNT_DELAY=3) → no gnt, state returns to IDLE; next arbitration with req=4'b0100 still starts from priority 3 (last unchanged).
- Reset mid-grant: rst=1 sampled at edge 10 while gnt[3]=1 → gnt=0 and busy=0 after edge 10; next winner for req=4'b1000 is requester 3 only after rst is released, since last=3 after reset gives priority 0,1,2,3.
- Contention: req=4'b0101 with last=0 → winner 2, gnt_id=2; req[0] stays pending and receives the grant after requester 2 releases.

Source files
------------

// File: rtl/req_gnt_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface req_gnt_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             busy;
  logic             expired;

  modport master (output req, input gnt, gnt_id, busy, expired);
  modport slave  (input req, output gnt, gnt_id, busy, expired);
endinterface

// File: rtl/req_gnt_arbiter.sv
// Round-robin req/gnt arbiter: grant appears GNT_DELAY edges after the winning
// request is sampled and is revoked after at most MAX_HOLD high cycles.
module req_gnt_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned GNT_DELAY = 2,
  parameter int unsigned MAX_HOLD  = 8
) (
  input  logic             clk,
  input  logic             rst,
  req_gnt_arbiter_if.slave bus
);
  localparam int unsigned ID_W     = $clog2(N_REQ);
  localparam int unsigned HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam int unsigned DLY_W    = (GNT_DELAY > 1) ? $clog2(GNT_DELAY) : 1;
  localparam int unsigned DLY_INIT = (GNT_DELAY > 1) ? GNT_DELAY - 2 : 0;
  localparam int unsigned RUN_W    = HOLD_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_e;

  state_e            state_q, state_nxt;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  gnt_q, gnt_nxt;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_nxt;
  logic [ID_W-1:0]   last_q, last_nxt;
  logic [HOLD_W-1:0] hold_q, hold_nxt;
  logic [DLY_W-1:0]  dly_q, dly_nxt;
  logic              busy_q, busy_nxt;
  logic              expired_q, expired_nxt;
  logic [ID_W-1:0]   winner;
  logic              owner_req;

  assign req         = bus.req;
  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.busy    = busy_q;
  assign bus.expired = expired_q;
  assign owner_req   = req[gnt_id_q];

  // Circular first-set search starting just after the previous owner.
  always_comb begin
    int unsigned idx;
    logic        found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(last_q) + 32'd1 + k) % N_REQ;
      if (!found && req[idx]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      last_q    <= ID_W'(N_REQ - 1);
      hold_q    <= '0;
      dly_q     <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      gnt_q     <= gnt_nxt;
      gnt_id_q  <= gnt_id_nxt;
      last_q    <= last_nxt;
      hold_q    <= hold_nxt;
      dly_q     <= dly_nxt;
      busy_q    <= busy_nxt;
      expired_q <= expired_nxt;
    end
  end

  // Next-state logic; a dropped owner request always wins over the counters.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (req != '0) state_nxt = (GNT_DELAY == 1) ? GRANT : WAIT;
      end
      WAIT: begin
        if (!owner_req)        state_nxt = IDLE;
        else if (dly_q == '0)  state_nxt = GRANT;
      end
      GRANT: begin
        if (!owner_req || hold_q == HOLD_W'(MAX_HOLD)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    gnt_nxt     = gnt_q;
    gnt_id_nxt  = gnt_id_q;
    last_nxt    = last_q;
    hold_nxt    = hold_q;
    dly_nxt     = dly_q;
    expired_nxt = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_nxt    = '0;
        gnt_id_nxt = '0;
        hold_nxt   = '0;
        dly_nxt    = '0;
        if (req != '0) begin
          gnt_id_nxt = winner;
          if (GNT_DELAY == 1) begin
            gnt_nxt  = N_REQ'(1) << winner;
            hold_nxt = HOLD_W'(1);
          end else begin
            dly_nxt = DLY_W'(DLY_INIT);
          end
        end
      end
      WAIT: begin
        if (!owner_req) begin
          gnt_id_nxt = '0;
          dly_nxt    = '0;
        end else if (dly_q == '0) begin
          gnt_nxt  = N_REQ'(1) << gnt_id_q;
          hold_nxt = HOLD_W'(1);
        end else begin
          dly_nxt = dly_q - DLY_W'(1);
        end
      end
      GRANT: begin
        if (!owner_req || hold_q == HOLD_W'(MAX_HOLD)) begin
          gnt_nxt     = '0;
          last_nxt    = gnt_id_q;
          gnt_id_nxt  = '0;
          hold_nxt    = '0;
          expired_nxt = owner_req;
        end else begin
          hold_nxt = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        gnt_nxt    = '0;
        gnt_id_nxt = '0;
      end
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  // Independent run-length of gnt high, used only to bound tenure in checks.
  logic [RUN_W-1:0] hi_run;
  always_ff @(posedge clk) begin
    if (rst)                                            hi_run <= '0;
    else if (gnt_q == '0)                               hi_run <= '0;
    else if (hi_run <= RUN_W'(MAX_HOLD))                hi_run <= hi_run + RUN_W'(1);
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
  a_hold:   assert property (@(posedge clk) disable iff (rst)
                             (gnt_q != '0) |-> (hi_run < RUN_W'(MAX_HOLD)));
  a_exp:    assert property (@(posedge clk) disable iff (rst) expired_q |-> (gnt_q == '0));

  for (genvar i = 0; i < N_REQ; i++) begin : g_rise
    a_rise: assert property (@(posedge clk) disable iff (rst)
                             $rose(gnt_q[i]) |-> $past(req[i], GNT_DELAY));
  end
endmodule

// File: tb/tb_req_gnt_arbiter.sv
// Directed bench for req_gnt_arbiter: three instances cover GNT_DELAY 2, 1 and 3.
module tb_req_gnt_arbiter;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  req_gnt_arbiter_if #(.N_REQ(4)) bus_a ();
  req_gnt_arbiter_if #(.N_REQ(4)) bus_b ();
  req_gnt_arbiter_if #(.N_REQ(4)) bus_c ();

  req_gnt_arbiter #(.N_REQ(4), .GNT_DELAY(2), .MAX_HOLD(8)) u_dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  req_gnt_arbiter #(.N_REQ(4), .GNT_DELAY(1), .MAX_HOLD(2)) u_dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));
  req_gnt_arbiter #(.N_REQ(4), .GNT_DELAY(3), .MAX_HOLD(8)) u_dut_c (
    .clk(clk), .rst(rst), .bus(bus_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] order [5];
    int         cnt;
    logic [3:0] oh;
    order = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

    rst = 1'b1;
    bus_a.req = '0;
    bus_b.req = '0;
    bus_c.req = '0;
    tick(); tick();
    check("rst_gnt",     32'(bus_a.gnt),     32'h0);
    check("rst_busy",    32'(bus_a.busy),    32'h0);
    check("rst_gnt_id",  32'(bus_a.gnt_id),  32'h0);
    check("rst_expired", 32'(bus_a.expired), 32'h0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(bus_a.busy), 32'h0);

    // Single requester, GNT_DELAY=2.
    bus_a.req = 4'b0010;
    tick();
    check("single_busy",   32'(bus_a.busy),   32'h1);
    check("single_gnt_id", 32'(bus_a.gnt_id), 32'h1);
    check("single_gnt_d0", 32'(bus_a.gnt),    32'h0);
    tick();
    check("single_gnt_d1", 32'(bus_a.gnt),    32'h2);
    tick();
    check("single_gnt_hold", 32'(bus_a.gnt),  32'h2);
    bus_a.req = 4'b0000;
    tick();
    check("single_rel_gnt",  32'(bus_a.gnt),     32'h0);
    check("single_rel_busy", 32'(bus_a.busy),    32'h0);
    check("single_rel_exp",  32'(bus_a.expired), 32'h0);

    // Round robin with all requesters held; reset first so priority starts at 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_a.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("rr_gnt_id", 32'(bus_a.gnt_id), 32'(order[t]));
      check("rr_arb_gnt", 32'(bus_a.gnt), 32'h0);
      oh = 4'b0001 << order[t];
      cnt = 0;
      for (int w = 0; w < 20; w++) begin
        tick();
        if (bus_a.gnt === oh) cnt++;
        else break;
      end
      check("rr_tenure",   32'(cnt),           32'd8);
      check("rr_rel_gnt",  32'(bus_a.gnt),     32'h0);
      check("rr_expired",  32'(bus_a.expired), 32'h1);
      check("rr_idle",     32'(bus_a.busy),    32'h0);
    end
    bus_a.req = 4'b0000;
    tick();
    check("rr_exp_pulse", 32'(bus_a.expired), 32'h0);
    check("rr_end_busy",  32'(bus_a.busy),    32'h0);

    // Contention with last=0: requester 2 wins, requester 0 follows.
    bus_a.req = 4'b0101;
    tick();
    check("cont_gnt_id", 32'(bus_a.gnt_id), 32'h2);
    tick();
    check("cont_gnt2", 32'(bus_a.gnt), 32'h4);
    bus_a.req = 4'b0001;
    tick();
    check("cont_rel", 32'(bus_a.gnt), 32'h0);
    tick();
    check("cont_next_id",   32'(bus_a.gnt_id), 32'h0);
    check("cont_next_busy", 32'(bus_a.busy),   32'h1);
    tick();
    check("cont_gnt0", 32'(bus_a.gnt), 32'h1);
    bus_a.req = 4'b0000;
    tick();

    // Reset in the middle of a grant to requester 3.
    bus_a.req = 4'b1000;
    tick();
    check("mid_gnt_id", 32'(bus_a.gnt_id), 32'h3);
    tick();
    check("mid_gnt3", 32'(bus_a.gnt), 32'h8);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_gnt",  32'(bus_a.gnt),    32'h0);
    check("mid_rst_busy", 32'(bus_a.busy),   32'h0);
    check("mid_rst_id",   32'(bus_a.gnt_id), 32'h0);
    rst = 1'b0;
    bus_a.req = 4'b1001;
    tick();
    check("post_rst_id", 32'(bus_a.gnt_id), 32'h0);
    tick();
    check("post_rst_gnt", 32'(bus_a.gnt), 32'h1);
    bus_a.req = 4'b0000;
    tick();

    // GNT_DELAY=1, MAX_HOLD=2: immediate grant, expiry, expired owner loses.
    bus_b.req = 4'b0011;
    tick();
    check("d1_gnt",    32'(bus_b.gnt),    32'h1);
    check("d1_busy",   32'(bus_b.busy),   32'h1);
    check("d1_gnt_id", 32'(bus_b.gnt_id), 32'h0);
    tick();
    check("d1_hold", 32'(bus_b.gnt), 32'h1);
    tick();
    check("d1_exp_gnt", 32'(bus_b.gnt),     32'h0);
    check("d1_expired", 32'(bus_b.expired), 32'h1);
    check("d1_idle",    32'(bus_b.busy),    32'h0);
    tick();
    check("d1_next_gnt", 32'(bus_b.gnt),     32'h2);
    check("d1_next_id",  32'(bus_b.gnt_id),  32'h1);
    check("d1_exp_clr",  32'(bus_b.expired), 32'h0);
    bus_b.req = 4'b0000;
    tick();

    // GNT_DELAY=3: abort during WAIT must not move the priority pointer.
    bus_c.req = 4'b0010;
    tick();
    check("abort_busy", 32'(bus_c.busy),   32'h1);
    check("abort_id",   32'(bus_c.gnt_id), 32'h1);
    bus_c.req = 4'b0000;
    tick();
    check("abort_idle", 32'(bus_c.busy), 32'h0);
    check("abort_gnt",  32'(bus_c.gnt),  32'h0);
    bus_c.req = 4'b0110;
    tick();
    check("abort_last", 32'(bus_c.gnt_id), 32'h1);
    tick();
    check("d3_gnt_d1", 32'(bus_c.gnt), 32'h0);
    tick();
    check("d3_gnt_d2", 32'(bus_c.gnt), 32'h2);
    bus_c.req = 4'b0000;
    tick();
    check("d3_rel", 32'(bus_c.gnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
